// File: rtl/display_pkg.sv
// Shared constants for the BCD seven-segment scanner: slot encodings and
// active-low {g,f,e,d,c,b,a} segment patterns.
package display_pkg;

  typedef enum logic [1:0] {
    S_ONES = 2'd0,
    S_TENS = 2'd1,
    S_HUND = 2'd2,
    S_GAP  = 2'd3
  } slot_e;

  localparam logic [3:0] AN_OFF    = 4'b1111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-low seven-segment pattern; non-BCD nibbles show a dash.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    unique case (nib_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seven_seg_scan.sv
// Latches 3-digit BCD results and scans them onto a 4-anode display.
// Optional leading-zero blanking: define LEADING_ZERO_BLANK_EN.
module bcd_seven_seg_scan
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] bcd_d_in,
  input  logic        bcd_rdy,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        disp_vld
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  slot_e         slot_q, slot_d;
  logic [11:0]   lat_q, lat_d;
  logic          vld_q, vld_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          tick;
  logic [3:0]    nib;
  logic [3:0]    sel;
  logic [6:0]    nib_seg;
  logic          blank_t, blank_h;

  seg7_decode u_dec (
    .nib_i (nib),
    .seg_o (nib_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  assign blank_h = (lat_q[11:8] == 4'd0);
  assign blank_t = blank_h && (lat_q[7:4] == 4'd0);
`else
  assign blank_h = 1'b0;
  assign blank_t = 1'b0;
`endif

  assign tick = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d  = tick ? '0 : cnt_q + CW'(1);
    lat_d  = bcd_rdy ? bcd_d_in : lat_q;
    vld_d  = vld_q | bcd_rdy;
    slot_d = slot_q;
    if (tick) begin
      unique case (slot_q)
        S_ONES: slot_d = S_TENS;
        S_TENS: slot_d = S_HUND;
        S_HUND: slot_d = S_GAP;
        S_GAP:  slot_d = S_ONES;
      endcase
    end
  end

  // Pins follow the current slot and latch with one register of delay
  always_comb begin
    nib   = lat_q[3:0];
    sel   = AN_OFF;
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    unique case (slot_q)
      S_ONES: begin
        nib = lat_q[3:0];
        sel = 4'b1110;
      end
      S_TENS: begin
        nib = lat_q[7:4];
        sel = blank_t ? AN_OFF : 4'b1101;
      end
      S_HUND: begin
        nib = lat_q[11:8];
        sel = blank_h ? AN_OFF : 4'b1011;
      end
      S_GAP: sel = AN_OFF;
    endcase
    if (vld_q && sel != AN_OFF) begin
      an_d  = sel;
      seg_d = nib_seg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      slot_q <= S_ONES;
      lat_q  <= 12'h000;
      vld_q  <= 1'b0;
      an_q   <= AN_OFF;
      seg_q  <= SEG_BLANK;
    end else begin
      cnt_q  <= cnt_d;
      slot_q <= slot_d;
      lat_q  <= lat_d;
      vld_q  <= vld_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign an       = an_q;
  assign seg      = seg_q;
  assign dp       = 1'b1;
  assign disp_vld = vld_q;

endmodule

// File: tb/tb_bcd_seven_seg_scan.sv
// Directed bench for bcd_seven_seg_scan with REFRESH_DIV=4.
module tb_bcd_seven_seg_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] bcd_d_in = 12'h000;
  logic        bcd_rdy = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        disp_vld;

  int checks = 0;
  int errors = 0;

  logic [11:0] m_lat;
  logic        m_vld;
  int          m_cnt;
  int          m_slot;

  bcd_seven_seg_scan #(.REFRESH_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bcd_d_in (bcd_d_in),
    .bcd_rdy  (bcd_rdy),
    .an       (an),
    .seg      (seg),
    .dp       (dp),
    .disp_vld (disp_vld)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] dec(input logic [3:0] n);
    logic [6:0] t [10];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
          7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    if (n > 4'd9) return 7'b0111111;
    return t[n];
  endfunction

  function automatic logic [3:0] m_an(input int s, input logic [11:0] l,
                                      input logic v);
    logic bh, bt;
`ifdef LEADING_ZERO_BLANK_EN
    bh = (l[11:8] == 4'd0);
    bt = bh && (l[7:4] == 4'd0);
`else
    bh = 1'b0;
    bt = 1'b0;
`endif
    if (!v) return 4'b1111;
    if (s == 0) return 4'b1110;
    if (s == 1) return bt ? 4'b1111 : 4'b1101;
    if (s == 2) return bh ? 4'b1111 : 4'b1011;
    return 4'b1111;
  endfunction

  function automatic logic [6:0] m_seg(input int s, input logic [11:0] l,
                                       input logic v);
    if (m_an(s, l, v) == 4'b1111) return 7'b1111111;
    if (s == 0) return dec(l[3:0]);
    if (s == 1) return dec(l[7:4]);
    return dec(l[11:8]);
  endfunction

  task automatic m_reset();
    m_lat  = 12'h000;
    m_vld  = 1'b0;
    m_cnt  = 0;
    m_slot = 0;
  endtask

  task automatic cyc(input logic r, input logic [11:0] d);
    logic [3:0] ea;
    logic [6:0] es;
    bcd_rdy  = r;
    bcd_d_in = d;
    @(posedge clk);
    ea = m_an(m_slot, m_lat, m_vld);
    es = m_seg(m_slot, m_lat, m_vld);
    if (r) begin
      m_lat = d;
      m_vld = 1'b1;
    end
    if (m_cnt == 3) begin
      m_cnt  = 0;
      m_slot = (m_slot + 1) % 4;
    end else begin
      m_cnt++;
    end
    @(negedge clk);
    chk("m_an", 16'(an), 16'(ea));
    chk("m_seg", 16'(seg), 16'(es));
    chk("m_vld", 16'(disp_vld), 16'(m_vld));
    chk("dp", 16'(dp), 16'h1);
    bcd_rdy = 1'b0;
  endtask

  // Pulse v at slot-0 count-0, then follow one full 16-cycle scan
  task automatic scan(input string tag, input logic [11:0] v,
                      input logic [15:0] ea, input logic [27:0] es);
    int j;
    cyc(1'b1, v);
    chk({tag, "_vld"}, 16'(disp_vld), 16'h1);
    for (int i = 0; i < 15; i++) begin
      cyc(1'b0, 12'h000);
      j = (i + 1) / 4;
      chk({tag, "_an"}, 16'(an), 16'(ea[j*4 +: 4]));
      chk({tag, "_seg"}, 16'(seg), 16'(es[j*7 +: 7]));
    end
  endtask

  initial begin
    m_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_an", 16'(an), 16'hF);
    chk("rst_seg", 16'(seg), 16'h7F);
    chk("rst_vld", 16'(disp_vld), 16'h0);
    chk("rst_dp", 16'(dp), 16'h1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 32; i++) begin
      cyc(1'b0, 12'h000);
      chk("idle_an", 16'(an), 16'hF);
      chk("idle_seg", 16'(seg), 16'h7F);
    end

    scan("t253", 12'h253, 16'hFBDE,
         {7'b1111111, 7'b0100100, 7'b0010010, 7'b0110000});
`ifdef LEADING_ZERO_BLANK_EN
    scan("t007", 12'h007, 16'hFFFE,
         {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111000});
    scan("t0A9", 12'h0A9, 16'hFFDE,
         {7'b1111111, 7'b1111111, 7'b0111111, 7'b0010000});
`else
    scan("t007", 12'h007, 16'hFBDE,
         {7'b1111111, 7'b1000000, 7'b1000000, 7'b1111000});
    scan("t0A9", 12'h0A9, 16'hFBDE,
         {7'b1111111, 7'b1000000, 7'b0111111, 7'b0010000});
`endif

    cyc(1'b0, 12'h000);
    cyc(1'b0, 12'h000);
    cyc(1'b0, 12'h000);
    cyc(1'b1, 12'h111);
    chk("tk_an", 16'(an), 16'hE);
    chk("tk_seg", 16'(seg), 16'(7'b0010000));
    cyc(1'b0, 12'h000);
    chk("tk_new_an", 16'(an), 16'hD);
    chk("tk_new_seg", 16'(seg), 16'(7'b1111001));
    cyc(1'b1, 12'h999);
    chk("mid_old_seg", 16'(seg), 16'(7'b1111001));
    cyc(1'b0, 12'h000);
    chk("mid_new_an", 16'(an), 16'hD);
    chk("mid_new_seg", 16'(seg), 16'(7'b0010000));

    cyc(1'b0, 12'h000);
    cyc(1'b0, 12'h000);
    cyc(1'b0, 12'h000);
    chk("hund_an", 16'(an), 16'hB);
    rst = 1'b1;
    #1;
    chk("arst_an", 16'(an), 16'hF);
    chk("arst_seg", 16'(seg), 16'h7F);
    chk("arst_vld", 16'(disp_vld), 16'h0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;

    scan("t_rs", 12'h253, 16'hFBDE,
         {7'b1111111, 7'b0100100, 7'b0010010, 7'b0110000});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got 0 exp 1");
    $fatal(1);
  end

endmodule
